// File: rtl/slave_resp_mux_pkg.sv
// -----------------------------------------------------------------------------
// slave_resp_mux_pkg
// Shared interconnect definitions used by the response multiplexer and its
// default-slave FSM:
//   resp_e    - bus response encoding (OKAY / ERROR)
//   ds_state_e - default-slave FSM states (IDLE, ERR1, ERR2)
//   idx_w()   - helper returning a safe index width for a slave count
// -----------------------------------------------------------------------------
package slave_resp_mux_pkg;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } resp_e;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  // A single-slave configuration still needs a 1-bit index register.
  function automatic int idx_w(input int num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

endpackage

// File: rtl/slave_resp_mux_default_slave.sv
// -----------------------------------------------------------------------------
// default_slave
// Two-cycle ERROR responder for transfers that hit no mapped slave.
// Present only when SLAVE_RESP_MUX_DEFAULT_SLAVE_EN is defined.
// Ports:
//   i_clk       - clock, rising edge
//   i_rst_n     - asynchronous active-low reset
//   i_capture   - address phase is being accepted this edge (bus hready=1)
//   i_unmapped  - accepted address phase is an active, unmapped transfer
//   o_hready    - ready contribution while responding (0 in ERR1, 1 in ERR2)
//   o_hresp     - response contribution (ERROR in ERR1/ERR2)
// -----------------------------------------------------------------------------
`ifdef SLAVE_RESP_MUX_DEFAULT_SLAVE_EN
module default_slave
  import slave_resp_mux_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_capture,
  input  logic i_unmapped,
  output logic o_hready,
  output logic o_hresp
);

  ds_state_e r_state;
  ds_state_e w_state_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= DS_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_hready    = 1'b1;
    o_hresp     = RESP_OKAY;
    case (r_state)
      DS_IDLE: begin
        if (i_capture && i_unmapped) w_state_nxt = DS_ERR1;
      end
      DS_ERR1: begin
        o_hready    = 1'b0;
        o_hresp     = RESP_ERROR;
        w_state_nxt = DS_ERR2;
      end
      DS_ERR2: begin
        // Bus is ready here, so a new address phase is accepted this edge;
        // another unmapped transfer restarts the error sequence directly.
        o_hready    = 1'b1;
        o_hresp     = RESP_ERROR;
        w_state_nxt = (i_capture && i_unmapped) ? DS_ERR1 : DS_IDLE;
      end
      default: w_state_nxt = DS_IDLE;
    endcase
  end

endmodule
`endif

// File: rtl/slave_resp_mux.sv
// -----------------------------------------------------------------------------
// slave_resp_mux
// Returns the response of the slave that owns the current data phase to the
// master. The owner is registered from the address-phase select whenever the
// bus is ready, and the owning slave's data/ready/response are then muxed
// through combinationally with no added latency.
// Optional feature: define SLAVE_RESP_MUX_DEFAULT_SLAVE_EN to give unmapped
// active transfers a two-cycle ERROR response; otherwise they complete as
// zero-wait idle data phases.
// Ports:
//   i_clk, i_rst_n     - clock / asynchronous active-low reset
//   i_hsel             - one-hot address-phase slave select (0 = unmapped)
//   i_htrans           - address-phase transfer active
//   i_hrdata[]         - per-slave read data
//   i_hreadyout[]      - per-slave ready
//   i_hresp[]          - per-slave response
//   o_hrdata           - read data to master
//   o_hready           - combined ready to master and all slaves
//   o_hresp            - combined response to master
// -----------------------------------------------------------------------------
module slave_resp_mux
  import slave_resp_mux_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_SLAVES-1:0] i_hsel,
  input  logic                  i_htrans,
  input  logic [DATA_WIDTH-1:0] i_hrdata    [NUM_SLAVES],
  input  logic                  i_hreadyout [NUM_SLAVES],
  input  logic                  i_hresp     [NUM_SLAVES],
  output logic [DATA_WIDTH-1:0] o_hrdata,
  output logic                  o_hready,
  output logic                  o_hresp
);

  localparam int IDX_W = idx_w(NUM_SLAVES);

  logic [IDX_W-1:0]      r_idx;
  logic                  r_owner_vld;
  logic                  r_dflt;

  logic [IDX_W-1:0]      w_sel_idx;
  logic                  w_sel_any;
  logic                  w_unmapped;
  logic                  w_ds_hready;
  logic                  w_ds_hresp;
  logic [DATA_WIDTH-1:0] w_hrdata;
  logic                  w_hready;
  logic                  w_hresp;

  // Lowest-index set bit wins if the decoder ever asserts more than one.
  always_comb begin
    w_sel_idx = '0;
    w_sel_any = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (i_hsel[i]) begin
        w_sel_idx = IDX_W'(i);
        w_sel_any = 1'b1;
      end
    end
  end

`ifdef SLAVE_RESP_MUX_DEFAULT_SLAVE_EN
  assign w_unmapped = i_htrans && !w_sel_any;

  default_slave u_default_slave (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_capture  (w_hready),
    .i_unmapped (w_unmapped),
    .o_hready   (w_ds_hready),
    .o_hresp    (w_ds_hresp)
  );
`else
  // Unmapped transfers are simply treated as idle data phases.
  assign w_unmapped  = 1'b0;
  assign w_ds_hready = 1'b1;
  assign w_ds_hresp  = RESP_OKAY;
`endif

  // Owner is held while the current data phase is stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx       <= '0;
      r_owner_vld <= 1'b0;
      r_dflt      <= 1'b0;
    end else if (w_hready) begin
      r_idx       <= w_sel_idx;
      r_owner_vld <= i_htrans && w_sel_any;
      r_dflt      <= w_unmapped;
    end
  end

  always_comb begin
    w_hrdata = '0;
    w_hready = 1'b1;
    w_hresp  = RESP_OKAY;
    if (r_owner_vld) begin
      w_hrdata = i_hrdata[r_idx];
      w_hready = i_hreadyout[r_idx];
      w_hresp  = i_hresp[r_idx];
    end else if (r_dflt) begin
      w_hready = w_ds_hready;
      w_hresp  = w_ds_hresp;
    end
  end

  assign o_hrdata = w_hrdata;
  assign o_hready = w_hready;
  assign o_hresp  = w_hresp;

endmodule

// File: tb/tb_slave_resp_mux.sv
module tb_slave_resp_mux;

  localparam int NS = 2;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic [NS-1:0] hsel;
  logic          htrans;
  logic [DW-1:0] hrdata    [NS];
  logic          hreadyout [NS];
  logic          hresp_in  [NS];
  logic [DW-1:0] o_hrdata;
  logic          o_hready;
  logic          o_hresp;

  int checks = 0;
  int errors = 0;

  slave_resp_mux #(.NUM_SLAVES(NS), .DATA_WIDTH(DW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_hsel      (hsel),
    .i_htrans    (htrans),
    .i_hrdata    (hrdata),
    .i_hreadyout (hreadyout),
    .i_hresp     (hresp_in),
    .o_hrdata    (o_hrdata),
    .o_hready    (o_hready),
    .o_hresp     (o_hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  hsel;
    logic        htrans;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        r0;
    logic        r1;
    logic        e0;
    logic        e1;
    logic [31:0] x_data;
    logic        x_rdy;
    logic        x_resp;
  } vec_t;

  vec_t vt [19];

`ifdef SLAVE_RESP_MUX_DEFAULT_SLAVE_EN
  localparam bit DS_EN = 1'b1;
`else
  localparam bit DS_EN = 1'b0;
`endif

  task automatic drive(input logic [1:0] s, input logic t,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic r0, input logic r1,
                       input logic e0, input logic e1);
    hsel = s; htrans = t;
    hrdata[0] = d0; hrdata[1] = d1;
    hreadyout[0] = r0; hreadyout[1] = r1;
    hresp_in[0] = e0; hresp_in[1] = e1;
  endtask

  task automatic check(input string name, input logic [31:0] xd,
                       input logic xr, input logic xe);
    checks++;
    if (o_hrdata !== xd || o_hready !== xr || o_hresp !== xe) begin
      errors++;
      $display("FAIL %s: got data=%h rdy=%b resp=%b, want data=%h rdy=%b resp=%b",
               name, o_hrdata, o_hready, o_hresp, xd, xr, xe);
    end
  endtask

  // One bus cycle: drive at the falling edge, sample 1ns later.
  task automatic cyc(input string name, input logic [1:0] s, input logic t,
                     input logic [31:0] d0, input logic [31:0] d1,
                     input logic r0, input logic r1,
                     input logic e0, input logic e1,
                     input logic [31:0] xd, input logic xr, input logic xe);
    @(negedge clk);
    drive(s, t, d0, d1, r0, r1, e0, e1);
    #1;
    check(name, xd, xr, xe);
  endtask

  initial begin
    // {hsel, htrans, d0, d1, r0, r1, e0, e1, x_data, x_rdy, x_resp}
    vt[0]  = '{2'b00, 1'b0, 32'h0,         32'h0,         1, 1, 0, 0, 32'h0,         1, 0};
    // slave1 read of CAFE_0001 (slave0 lines deliberately noisy)
    vt[1]  = '{2'b10, 1'b1, 32'h1111_1111, 32'h0,         0, 1, 1, 0, 32'h0,         1, 0};
    vt[2]  = '{2'b00, 1'b0, 32'h1111_1111, 32'hCAFE_0001, 0, 1, 1, 0, 32'hCAFE_0001, 1, 0};
    // slave0 stalls 3 cycles while the next address (slave1) is held
    vt[3]  = '{2'b01, 1'b1, 32'h0,         32'h0,         1, 1, 0, 0, 32'h0,         1, 0};
    vt[4]  = '{2'b10, 1'b1, 32'h0000_000A, 32'h2222_2222, 0, 1, 0, 0, 32'h0000_000A, 0, 0};
    vt[5]  = '{2'b10, 1'b1, 32'h0000_000A, 32'h2222_2222, 0, 1, 0, 0, 32'h0000_000A, 0, 0};
    vt[6]  = '{2'b10, 1'b1, 32'h0000_000A, 32'h2222_2222, 0, 1, 0, 0, 32'h0000_000A, 0, 0};
    vt[7]  = '{2'b10, 1'b1, 32'h0000_00D0, 32'h2222_2222, 1, 1, 0, 0, 32'h0000_00D0, 1, 0};
    vt[8]  = '{2'b00, 1'b0, 32'h3333_3333, 32'h0000_000B, 1, 0, 0, 0, 32'h0000_000B, 0, 0};
    vt[9]  = '{2'b00, 1'b0, 32'h3333_3333, 32'h0000_00B2, 1, 1, 0, 0, 32'h0000_00B2, 1, 0};
    // slave1 two-cycle ERROR then slave0 OKAY A5 back-to-back
    vt[10] = '{2'b10, 1'b1, 32'h0,         32'h0,         1, 1, 0, 0, 32'h0,         1, 0};
    vt[11] = '{2'b01, 1'b1, 32'h0,         32'h0,         1, 0, 0, 1, 32'h0,         0, 1};
    vt[12] = '{2'b01, 1'b1, 32'h0,         32'h0,         1, 1, 0, 1, 32'h0,         1, 1};
    vt[13] = '{2'b00, 1'b0, 32'h0000_00A5, 32'h4444_4444, 1, 1, 0, 1, 32'h0000_00A5, 1, 0};
    vt[14] = '{2'b00, 1'b0, 32'h5555_5555, 32'h4444_4444, 1, 1, 0, 0, 32'h0,         1, 0};
    // multiple selects -> lowest index
    vt[15] = '{2'b11, 1'b1, 32'h0,         32'h0,         1, 1, 0, 0, 32'h0,         1, 0};
    vt[16] = '{2'b00, 1'b0, 32'h0000_0077, 32'h0000_0088, 1, 0, 0, 1, 32'h0000_0077, 1, 0};
    // select with htrans=0 is an idle data phase
    vt[17] = '{2'b10, 1'b0, 32'h0,         32'h0,         1, 1, 0, 0, 32'h0,         1, 0};
    vt[18] = '{2'b00, 1'b0, 32'h0,         32'h0000_0099, 1, 0, 0, 1, 32'h0,         1, 0};

    rst_n = 1'b0;
    drive(2'b00, 1'b0, 32'h0, 32'h0, 1, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      cyc($sformatf("vec%0d", i), vt[i].hsel, vt[i].htrans, vt[i].d0, vt[i].d1,
          vt[i].r0, vt[i].r1, vt[i].e0, vt[i].e1,
          vt[i].x_data, vt[i].x_rdy, vt[i].x_resp);
    end

    // Unmapped active transfer (slave lines noisy throughout).
    cyc("unm_addr", 2'b00, 1'b1, 32'hDEAD_0000, 32'hDEAD_0001, 0, 0, 1, 1, 32'h0, 1, 0);
    cyc("unm_c1",   2'b00, 1'b0, 32'hDEAD_0000, 32'hDEAD_0001, 0, 0, 1, 1, 32'h0, !DS_EN, DS_EN);
    cyc("unm_c2",   2'b00, 1'b0, 32'hDEAD_0000, 32'hDEAD_0001, 0, 0, 1, 1, 32'h0, 1'b1, DS_EN);
    cyc("unm_c3",   2'b00, 1'b0, 32'hDEAD_0000, 32'hDEAD_0001, 0, 0, 1, 1, 32'h0, 1, 0);

    // Slave0 address accepted in the ERR2 cycle.
    cyc("b2b_addr", 2'b00, 1'b1, 32'h0000_005A, 32'h0, 1, 1, 0, 0, 32'h0, 1, 0);
    cyc("b2b_c1",   2'b01, 1'b1, 32'h0000_005A, 32'h0, 1, 1, 0, 0, 32'h0, !DS_EN, DS_EN);
    if (DS_EN) begin
      cyc("b2b_c2", 2'b01, 1'b1, 32'h0000_005A, 32'h0, 1, 1, 0, 0, 32'h0, 1, 1);
    end else begin
      cyc("b2b_c2", 2'b01, 1'b1, 32'h0000_005A, 32'h0, 1, 1, 0, 0, 32'h0000_005A, 1, 0);
    end
    cyc("b2b_c3",   2'b00, 1'b0, 32'h0000_005A, 32'h0, 1, 1, 0, 0, 32'h0000_005A, 1, 0);
    cyc("b2b_c4",   2'b00, 1'b0, 32'h0000_005A, 32'h0, 1, 1, 0, 0, 32'h0, 1, 0);

    // Unmapped accepted in ERR2 restarts the error sequence.
    cyc("rr_addr",  2'b00, 1'b1, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0, 1, 0);
    cyc("rr_c1",    2'b00, 1'b1, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0, !DS_EN, DS_EN);
    cyc("rr_c2",    2'b00, 1'b1, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0, 1'b1, DS_EN);
    cyc("rr_c3",    2'b00, 1'b0, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0, !DS_EN, DS_EN);
    cyc("rr_c4",    2'b00, 1'b0, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0, 1'b1, DS_EN);
    cyc("rr_c5",    2'b00, 1'b0, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0, 1, 0);

    // Reset pulsed during ERR1.
    cyc("rst_err_addr", 2'b00, 1'b1, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0, 1, 0);
    cyc("rst_err_c1",   2'b00, 1'b0, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0, !DS_EN, DS_EN);
    rst_n = 1'b0;
    #1;
    check("rst_err_during", 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_err_release", 32'h0, 1'b1, 1'b0);
    cyc("rst_err_after", 2'b00, 1'b0, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0, 1, 0);

    // Reset pulsed while slave0 is stalling.
    cyc("rst_wait_addr", 2'b01, 1'b1, 32'h0000_0033, 32'h0, 0, 1, 0, 0, 32'h0, 1, 0);
    cyc("rst_wait_c1",   2'b00, 1'b0, 32'h0000_0033, 32'h0, 0, 1, 0, 0, 32'h0000_0033, 0, 0);
    rst_n = 1'b0;
    #1;
    check("rst_wait_during", 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_wait_release", 32'h0, 1'b1, 1'b0);
    cyc("rst_wait_after", 2'b00, 1'b0, 32'h0000_0033, 32'h0, 0, 1, 1, 0, 32'h0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
